// File: rtl/disp_pkg.sv
// ============================================================================
// Module  : disp_pkg
// Brief   : Shared types and constants for the dispense scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int SLOT_W      = 3;
  localparam int MED_W       = 2;
  localparam int NUM_SCHED   = 3;
  localparam int NUM_JOBS    = 6;
  localparam int TIMEOUT_CYC = 15;
  localparam int ENTRY_W     = SLOT_W + 2 * MED_W;
  localparam int JOB_IDX_W   = 3;
  localparam int SCHED_W     = 2;
  localparam int MED_A_LSB   = SLOT_W;
  localparam int MED_B_LSB   = SLOT_W + MED_W;

  localparam int SCHED_MORN  = 0;
  localparam int SCHED_MID   = 1;
  localparam int SCHED_NIGHT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dispense_scheduler_if.sv
// ============================================================================
// Module  : dispense_scheduler_if
// Brief   : Job handshake between the scheduler (master) and actuator (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dispense_scheduler_if;
  import disp_pkg::*;

  logic               disp_valid;
  logic [MED_W-1:0]   disp_med;
  logic [SCHED_W-1:0] disp_sched;
  logic               disp_ack;

  modport master (output disp_valid, disp_med, disp_sched, input  disp_ack);
  modport slave  (input  disp_valid, disp_med, disp_sched, output disp_ack);

endinterface

`default_nettype wire

// File: rtl/disp_prio_sel.sv
// ============================================================================
// Module  : disp_prio_sel
// Brief   : Fixed-priority picker, lowest set request index wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_prio_sel
  import disp_pkg::*;
(
  input  logic [NUM_JOBS-1:0]  req,
  output logic [JOB_IDX_W-1:0] idx,
  output logic                 any
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = NUM_JOBS - 1; i >= 0; i--) begin
      if (req[i]) idx = JOB_IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/dispense_scheduler.sv
// ============================================================================
// Module  : dispense_scheduler
// Brief   : Three-schedule medicine dispense scheduler with actuator handshake.
//           Define DISP_TIMEOUT_EN to drop jobs the actuator never accepts.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dispense_scheduler
  import disp_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 ld_morn,
  input  logic                 ld_mid,
  input  logic                 ld_night,
  input  logic [ENTRY_W-1:0]   data_in_morn,
  input  logic [ENTRY_W-1:0]   data_in_mid,
  input  logic [ENTRY_W-1:0]   data_in_night,
  input  logic                 clr_err,
  dispense_scheduler_if.master disp,
  output logic [SLOT_W-1:0]    slot,
  output logic [NUM_JOBS-1:0]  pending,
  output logic [NUM_SCHED-1:0] missed,
  output logic                 timeout_err
);

  logic [NUM_SCHED-1:0][ENTRY_W-1:0] entry;
  logic [NUM_SCHED-1:0][ENTRY_W-1:0] data_vec;
  logic [NUM_SCHED-1:0]              valid, ld_vec, match, overrun;
  logic [NUM_JOBS-1:0]               set_mask, ld_clr, done_mask, inflight_mask, pend_kept;
  logic [SLOT_W-1:0]                 slot_next;
  logic [JOB_IDX_W-1:0]              sel_idx, sel_idx_q, issue_idx;
  logic                              sel_any, sel_any_q;
  logic [MED_W-1:0]                  med_q, med_sel;
  logic [SCHED_W-1:0]                sched_q;
  logic                              issue_ack, start_job, timeout_hit;
  state_t                            state, state_next;

  assign ld_vec    = {ld_night, ld_mid, ld_morn};
  assign data_vec  = {data_in_night, data_in_mid, data_in_morn};
  assign slot_next = slot + SLOT_W'(1);

  assign inflight_mask = (state == ISSUE) ? (NUM_JOBS'(1) << issue_idx) : '0;
  assign done_mask     = (issue_ack || timeout_hit) ? inflight_mask : '0;
  assign pend_kept     = pending & ~(done_mask | ld_clr);

  // Match compares the pre-load entry; a same-cycle load only affects later ticks.
  for (genvar s = 0; s < NUM_SCHED; s++) begin : g_sched
    assign match[s]          = tick && valid[s] && (entry[s][SLOT_W-1:0] == slot_next);
    assign set_mask[2*s +: 2] = {2{match[s]}};
    assign ld_clr[2*s +: 2]   = {2{ld_vec[s]}} & ~inflight_mask[2*s +: 2];
    assign overrun[s]        = match[s] && (|pend_kept[2*s +: 2]);
  end

  disp_prio_sel u_prio_sel (
    .req (pending),
    .idx (sel_idx),
    .any (sel_any)
  );

  assign med_sel = sel_idx_q[0] ? entry[sel_idx_q[2:1]][MED_B_LSB +: MED_W]
                                : entry[sel_idx_q[2:1]][MED_A_LSB +: MED_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry <= '0;
      valid <= '0;
    end else begin
      for (int s = 0; s < NUM_SCHED; s++) begin
        if (ld_vec[s]) begin
          entry[s] <= data_vec[s];
          valid[s] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot      <= '0;
      pending   <= '0;
      missed    <= '0;
      sel_idx_q <= '0;
      sel_any_q <= 1'b0;
      issue_idx <= '0;
      med_q     <= '0;
      sched_q   <= '0;
    end else begin
      if (tick) slot <= slot_next;
      pending   <= pend_kept | set_mask;
      missed    <= (missed & ~{NUM_SCHED{clr_err}}) | overrun;
      sel_idx_q <= sel_idx;
      sel_any_q <= sel_any;
      if (start_job) begin
        issue_idx <= sel_idx_q;
        med_q     <= med_sel;
        sched_q   <= sel_idx_q[2:1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_job) state_next = ISSUE;
      ISSUE:   if (issue_ack || timeout_hit) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The registered pick can trail pending by a cycle, so confirm the bit is still live.
  always_comb begin
    disp.disp_valid = (state == ISSUE);
    issue_ack       = (state == ISSUE) && disp.disp_ack;
    start_job       = (state == IDLE) && sel_any_q && pending[sel_idx_q];
  end

  assign disp.disp_med   = med_q;
  assign disp.disp_sched = sched_q;

`ifdef DISP_TIMEOUT_EN
  logic [3:0] timer;

  assign timeout_hit = (state == ISSUE) && !disp.disp_ack && (timer == 4'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timer       <= (state == ISSUE && state_next == ISSUE) ? timer + 4'd1 : 4'd0;
      timeout_err <= (timeout_err && !clr_err) || timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

`default_nettype wire
